full_adder: RTL and testbench

- Registered, parameterizable-width binary adder: s = a + b + cin, carry-out c.
- Built as a ripple chain of gate-level 1-bit full-adder cells.
- Default WIDTH=1 gives the classic single-bit full adder with one-cycle registered outputs.
- Used as an arithmetic leaf in datapaths; a valid strobe accompanies each result.

---
 rtl/full_adder_pkg.sv | 15 +
 rtl/full_adder_cell.sv | 23 ++
 rtl/full_adder.sv | 89 ++++++++
 tb/tb_full_adder.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// Shared constants and helpers for the registered ripple-carry adder.
// Imported by full_adder and full_adder_cell.
package full_adder_pkg;

  localparam int WIDTH_MAX = 64;

  localparam logic [WIDTH_MAX-1:0] S_RST = '0;
  localparam logic                 C_RST = 1'b0;

  // {carry, sum} result width for a given operand width
  function automatic int res_w(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Gate-level 1-bit full-adder cell, one link of the ripple chain.
// Ports: a, b, ci in; s (sum), co (carry out) out. Purely combinational.
module full_adder_cell
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_x;
  logic w_g;
  logic w_p;

  xor u_x0 (w_x, a, b);
  xor u_x1 (s, w_x, ci);
  and u_a0 (w_g, a, b);
  and u_a1 (w_p, w_x, ci);
  or  u_o0 (co, w_g, w_p);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple adder {c,s} = a + b + cin, 1-cycle latency.
// Ports: clk, rst (sync, active-high), in_valid, a, b, cin -> s, c,
// out_valid; ovf (signed overflow) only when FULL_ADDER_OVERFLOW_EN.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             c,
`ifdef FULL_ADDER_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  localparam int RW = res_w(WIDTH);

  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("full_adder: WIDTH out of range");
  end

  logic [WIDTH:0]   w_k;
  logic [WIDTH-1:0] w_s;
  logic [RW-1:0]    w_res;

  assign w_k[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (w_k[i]),
      .s  (w_s[i]),
      .co (w_k[i+1])
    );
  end

  assign w_res = {w_k[WIDTH], w_s};

  logic [WIDTH-1:0] r_s;
  logic             r_c;
  logic             r_v;

  // Result registers load only on in_valid, so X on idle
  // operands never reaches s/c.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s <= S_RST[WIDTH-1:0];
      r_c <= C_RST;
      r_v <= 1'b0;
    end else begin
      r_v <= in_valid;
      if (in_valid) begin
        r_s <= w_res[WIDTH-1:0];
        r_c <= w_res[RW-1];
      end
    end
  end

  assign s         = r_s;
  assign c         = r_c;
  assign out_valid = r_v;

`ifdef FULL_ADDER_OVERFLOW_EN
  logic w_ovf;
  logic r_ovf;

  // Signed overflow: carry into MSB differs from carry out of it
  assign w_ovf = w_k[WIDTH] ^ w_k[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (in_valid) begin
      r_ovf <= w_ovf;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH 1, 8 and 16.
// Expected results are queued at drive time and popped after the edge.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v1 = 0, a1 = 0, b1 = 0, c1i = 0;
  logic        s1, c1, vo1;
  logic        v8 = 0, c8i = 0;
  logic [7:0]  a8 = 0, b8 = 0, s8;
  logic        c8, vo8;
  logic        v16 = 0, c16i = 0;
  logic [15:0] a16 = 0, b16 = 0, s16;
  logic        c16, vo16;
`ifdef FULL_ADDER_OVERFLOW_EN
  logic        ov1, ov8, ov16;
`endif

  full_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1),
    .a(a1), .b(b1), .cin(c1i), .s(s1), .c(c1),
`ifdef FULL_ADDER_OVERFLOW_EN
    .ovf(ov1),
`endif
    .out_valid(vo1));

  full_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8),
    .a(a8), .b(b8), .cin(c8i), .s(s8), .c(c8),
`ifdef FULL_ADDER_OVERFLOW_EN
    .ovf(ov8),
`endif
    .out_valid(vo8));

  full_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(v16),
    .a(a16), .b(b16), .cin(c16i), .s(s16), .c(c16),
`ifdef FULL_ADDER_OVERFLOW_EN
    .ovf(ov16),
`endif
    .out_valid(vo16));

  typedef struct {
    logic [16:0] cs;
    logic        vld;
    logic        ovf;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];
  exp_t q16[$];

  logic [16:0] m1 = 0, m8 = 0, m16 = 0;
  logic        mo1 = 0, mo8 = 0, mo16 = 0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic drv1(input logic v, input logic xa, xb, xc);
    exp_t e;
    v1 = v; a1 = xa; b1 = xb; c1i = xc;
    if (rst) begin
      m1 = 0; mo1 = 0;
    end else if (v) begin
      m1  = 17'(xa) + 17'(xb) + 17'(xc);
      mo1 = (xa == xb) && (m1[0] != xa);
    end
    e.cs = m1; e.vld = v && !rst; e.ovf = mo1;
    q1.push_back(e);
  endtask

  task automatic drv8(input logic v, input logic [7:0] xa, xb,
                      input logic xc);
    exp_t e;
    v8 = v; a8 = xa; b8 = xb; c8i = xc;
    if (rst) begin
      m8 = 0; mo8 = 0;
    end else if (v) begin
      m8  = 17'(xa) + 17'(xb) + 17'(xc);
      mo8 = (xa[7] == xb[7]) && (m8[7] != xa[7]);
    end
    e.cs = m8; e.vld = v && !rst; e.ovf = mo8;
    q8.push_back(e);
  endtask

  task automatic drv16(input logic v, input logic [15:0] xa, xb,
                       input logic xc);
    exp_t e;
    v16 = v; a16 = xa; b16 = xb; c16i = xc;
    if (rst) begin
      m16 = 0; mo16 = 0;
    end else if (v) begin
      m16  = 17'(xa) + 17'(xb) + 17'(xc);
      mo16 = (xa[15] == xb[15]) && (m16[15] != xa[15]);
    end
    e.cs = m16; e.vld = v && !rst; e.ovf = mo16;
    q16.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    drv1(1'b0, 1'b0, 1'b0, 1'b0);
    drv8(1'b1, 8'h40, 8'h40, 1'b0);
    drv16(1'b0, 16'h0, 16'h0, 1'b0);
    @(posedge clk); #1;
    e = q1.pop_front(); n_cmp++;
    if ({c1, s1, vo1} !== {e.cs[1:0], e.vld}) begin
      n_bad++;
      $display("FAIL reset_w1: got c=%b s=%b v=%b want 0 0 0",
               c1, s1, vo1);
    end
    e = q8.pop_front(); n_cmp++;
    if ({c8, s8, vo8} !== {e.cs[8:0], e.vld}) begin
      n_bad++;
      $display("FAIL reset_w8: got c=%b s=%h v=%b want 0 00 0",
               c8, s8, vo8);
    end
    e = q16.pop_front(); n_cmp++;
    if ({c16, s16, vo16} !== {e.cs, e.vld}) begin
      n_bad++;
      $display("FAIL reset_w16: got c=%b s=%h v=%b want 0 0000 0",
               c16, s16, vo16);
    end
`ifdef FULL_ADDER_OVERFLOW_EN
    n_cmp++;
    if ({ov1, ov8, ov16} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_ovf: got %b%b%b want 000", ov1, ov8, ov16);
    end
`endif
    rst = 1'b0;
    drv8(1'b0, 8'h0, 8'h0, 1'b0);
    @(posedge clk); #1;
    void'(q1.pop_front());
    e = q8.pop_front();
    void'(q16.pop_front());
  endtask

  task automatic test_exhaustive_w1();
    logic [1:0] tbl [8];
    logic [2:0] idx;
    exp_t e;
    tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      drv1(1'b1, idx[2], idx[1], idx[0]);
      @(posedge clk); #1;
      e = q1.pop_front(); n_cmp++;
      if ({c1, s1} !== tbl[i] || vo1 !== 1'b1) begin
        n_bad++;
        $display("FAIL exh_w1[%0d]: got cs=%b v=%b want cs=%b v=1",
                 i, {c1, s1}, vo1, tbl[i]);
      end
`ifdef FULL_ADDER_OVERFLOW_EN
      n_cmp++;
      if (ov1 !== e.ovf) begin
        n_bad++;
        $display("FAIL exh_w1_ovf[%0d]: got %b want %b", i, ov1, e.ovf);
      end
`endif
    end
    drv1(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    void'(q1.pop_front());
  endtask

  task automatic run8(input string nm, input logic v,
                      input logic [7:0] xa, xb, input logic xc);
    exp_t e;
    drv8(v, xa, xb, xc);
    @(posedge clk); #1;
    e = q8.pop_front(); n_cmp++;
    if ({c8, s8} !== e.cs[8:0] || vo8 !== e.vld) begin
      n_bad++;
      $display("FAIL %s: got c=%b s=%h v=%b want c=%b s=%h v=%b",
               nm, c8, s8, vo8, e.cs[8], e.cs[7:0], e.vld);
    end
`ifdef FULL_ADDER_OVERFLOW_EN
    n_cmp++;
    if (ov8 !== e.ovf) begin
      n_bad++;
      $display("FAIL %s_ovf: got %b want %b", nm, ov8, e.ovf);
    end
`endif
  endtask

  task automatic test_wrap_w8();
    run8("wrap_ff_01", 1'b1, 8'hFF, 8'h01, 1'b0);
    n_cmp++;
    if ({c8, s8} !== 9'h100) begin
      n_bad++;
      $display("FAIL wrap_ff_01_const: got %h want 100", {c8, s8});
    end
    run8("wrap_ff_ff_1", 1'b1, 8'hFF, 8'hFF, 1'b1);
    n_cmp++;
    if ({c8, s8} !== 9'h1FF) begin
      n_bad++;
      $display("FAIL wrap_ff_ff_1_const: got %h want 1ff", {c8, s8});
    end
  endtask

  task automatic test_hold_w8();
    run8("hold_load", 1'b1, 8'h12, 8'h34, 1'b0);
    run8("hold_idle", 1'b0, 8'hAA, 8'h34, 1'b0);
    n_cmp++;
    if ({c8, s8, vo8} !== {9'h046, 1'b0}) begin
      n_bad++;
      $display("FAIL hold_const: got c=%b s=%h v=%b want 0 46 0",
               c8, s8, vo8);
    end
    run8("hold_idle2", 1'b0, 8'h55, 8'h66, 1'b1);
  endtask

  task automatic test_x_idle_w16();
    exp_t e;
    drv16(1'b1, 16'h1234, 16'h4321, 1'b1);
    @(posedge clk); #1;
    void'(q16.pop_front());
    drv16(1'b0, 16'hxxxx, 16'hxxxx, 1'bx);
    @(posedge clk); #1;
    e = q16.pop_front(); n_cmp++;
    if ({c16, s16} !== 17'h05556 || vo16 !== e.vld) begin
      n_bad++;
      $display("FAIL x_idle: got c=%b s=%h v=%b want c=0 s=5556 v=0",
               c16, s16, vo16);
    end
  endtask

  task automatic test_reset_mid();
    run8("mid_pre", 1'b1, 8'h11, 8'h22, 1'b0);
    rst = 1'b1;
    run8("mid_rst", 1'b1, 8'h70, 8'h10, 1'b0);
    m1 = 0; mo1 = 0; m16 = 0; mo16 = 0;
    n_cmp++;
    if ({c8, s8, vo8} !== 10'h000) begin
      n_bad++;
      $display("FAIL mid_rst_const: got c=%b s=%h v=%b want 0 00 0",
               c8, s8, vo8);
    end
    rst = 1'b0;
    run8("mid_idle", 1'b0, 8'h00, 8'h00, 1'b0);
    run8("mid_resume", 1'b1, 8'h70, 8'h10, 1'b1);
  endtask

  task automatic test_ovf_w8();
    run8("ovf_7f_01", 1'b1, 8'h7F, 8'h01, 1'b0);
    run8("ovf_80_80", 1'b1, 8'h80, 8'h80, 1'b0);
    run8("ovf_01_01", 1'b1, 8'h01, 8'h01, 1'b0);
    run8("ovf_hold", 1'b0, 8'h7F, 8'h7F, 1'b1);
    run8("ovf_ff_ff", 1'b1, 8'hFF, 8'hFF, 1'b0);
  endtask

  task automatic test_back_to_back_w16();
    exp_t e;
    int bad0;
    bad0 = n_bad;
    for (int i = 0; i < 1000; i++) begin
      drv16(1'b1, 16'($urandom_range(0, 65535)),
            16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
      e = q16.pop_front(); n_cmp++;
      if ({c16, s16} !== e.cs || vo16 !== 1'b1) begin
        n_bad++;
        if (n_bad - bad0 < 10)
          $display("FAIL rand16[%0d]: got %h v=%b want %h v=1",
                   i, {c16, s16}, vo16, e.cs);
      end
`ifdef FULL_ADDER_OVERFLOW_EN
      n_cmp++;
      if (ov16 !== e.ovf) begin
        n_bad++;
        if (n_bad - bad0 < 10)
          $display("FAIL rand16_ovf[%0d]: got %b want %b",
                   i, ov16, e.ovf);
      end
`endif
    end
    drv16(1'b0, 16'h0, 16'h0, 1'b0);
    @(posedge clk); #1;
    e = q16.pop_front(); n_cmp++;
    if (vo16 !== 1'b0 || {c16, s16} !== e.cs) begin
      n_bad++;
      $display("FAIL rand16_tail: got %h v=%b want %h v=0",
               {c16, s16}, vo16, e.cs);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_exhaustive_w1();
    test_wrap_w8();
    test_hold_w8();
    test_x_idle_w16();
    test_reset_mid();
    test_ovf_w8();
    test_back_to_back_w16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
